// File: rtl/sum_window_accum_if.sv
// sum_window_accum_if: sample input and window-result handshakes for sum_window_accum.
interface sum_window_accum_if #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4,
  parameter int ACC_WIDTH = 10
);
  localparam int CW = $clog2(COUNT + 1);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic [CW-1:0]        out_count;
  logic                 out_ovf;
  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );
  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/sum_window_accum.sv
// sum_window_accum: accumulates up to COUNT samples per window, emits total/count/carry flag.
module sum_window_accum #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4,
  parameter int ACC_WIDTH = 10
) (
  input logic clk,
  input logic rst,
  sum_window_accum_if.slave bus
);
  localparam int CW = $clog2(COUNT + 1);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, sum_q, sum_d, new_acc;
  logic [CW-1:0]        cnt_q, cnt_d, ocnt_q, ocnt_d, new_cnt;
  logic                 ovf_q, ovf_d, oovf_q, oovf_d, new_ovf;
  logic [ACC_WIDTH:0]   add_w;
  logic                 accept, take, close;
  assign bus.out_valid = state_q == HOLD;
  assign bus.in_ready  = state_q == HOLD ? bus.out_ready : ~rst;
  assign bus.out_sum   = sum_q;
  assign bus.out_count = ocnt_q;
  assign bus.out_ovf   = oovf_q;
  assign accept = bus.in_valid & bus.in_ready;
  assign take   = bus.out_valid & bus.out_ready;
  // acc/cnt/ovf are already cleared while in HOLD, so a take-cycle sample starts a fresh window
  always_comb begin
    add_w   = {1'b0, acc_q} + (ACC_WIDTH + 1)'(bus.in_data);
    new_acc = accept ? add_w[ACC_WIDTH-1:0] : acc_q;
    new_cnt = cnt_q + CW'(accept);
    new_ovf = ovf_q | (accept & add_w[ACC_WIDTH]);
    close   = (accept & (cnt_q == CW'(COUNT - 1))) |
              (state_q == ACCUM & bus.flush & (cnt_q != '0 | accept));
    acc_d   = close ? '0 : new_acc;
    cnt_d   = close ? '0 : new_cnt;
    ovf_d   = close ? 1'b0 : new_ovf;
    sum_d   = close ? new_acc : sum_q;
    ocnt_d  = close ? new_cnt : ocnt_q;
    oovf_d  = close ? new_ovf : oovf_q;
    state_d = close ? HOLD : take ? ACCUM : state_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
      ocnt_q  <= '0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
      ocnt_q  <= ocnt_d;
      oovf_q  <= oovf_d;
    end
  end
endmodule
